// File: rtl/spi_reg_arbiter.sv
// Register bank arbiter: fixed-priority SPI command path with a one-deep pending slot,
// and a level req/ack local port. All outputs are registered except busy.
module spi_reg_arbiter #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_rd_req_i,
    input  logic          spi_wr_req_i,
    input  logic [AW-1:0] spi_addr_i,
    input  logic [DW-1:0] spi_wdata_i,
    output logic [DW-1:0] spi_rdata_o,
    output logic          spi_rvalid_o,
    output logic          spi_overrun_o,
    input  logic          loc_req_i,
    input  logic          loc_we_i,
    input  logic [AW-1:0] loc_addr_i,
    input  logic [DW-1:0] loc_wdata_i,
    output logic          loc_ack_o,
    output logic [DW-1:0] loc_rdata_o,
    output logic          bank_en_o,
    output logic          bank_we_o,
    output logic [AW-1:0] bank_addr_o,
    output logic [DW-1:0] bank_wdata_o,
    input  logic [DW-1:0] bank_rdata_i,
    output logic          busy_o
);

    typedef enum logic [2:0] {
        StIdle, StSpiAcc, StSpiWait, StLocAcc, StLocWait, StLocDone
    } state_e;

    localparam logic [1:0] CntLast = 2'(RD_LAT - 1);

    state_e        state_q, state_d;
    logic          slot_full_q, slot_full_d;
    logic          slot_we_q, slot_we_d;
    logic [AW-1:0] slot_addr_q, slot_addr_d;
    logic [DW-1:0] slot_wdata_q, slot_wdata_d;
    logic          bank_en_q, bank_en_d;
    logic          bank_we_q, bank_we_d;
    logic [AW-1:0] bank_addr_q, bank_addr_d;
    logic [DW-1:0] bank_wdata_q, bank_wdata_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] spi_rdata_q, spi_rdata_d;
    logic          spi_rvalid_q, spi_rvalid_d;
    logic          spi_overrun_q, spi_overrun_d;
    logic          loc_ack_q, loc_ack_d;
    logic [DW-1:0] loc_rdata_q, loc_rdata_d;
    logic          spi_pulse, slot_drain, spi_direct;

    assign spi_pulse = spi_rd_req_i ^ spi_wr_req_i;

    always_comb begin
        state_d       = state_q;
        slot_full_d   = slot_full_q;
        slot_we_d     = slot_we_q;
        slot_addr_d   = slot_addr_q;
        slot_wdata_d  = slot_wdata_q;
        bank_en_d     = 1'b0;
        bank_we_d     = bank_we_q;
        bank_addr_d   = bank_addr_q;
        bank_wdata_d  = bank_wdata_q;
        cnt_d         = cnt_q;
        spi_rdata_d   = spi_rdata_q;
        spi_rvalid_d  = 1'b0;
        spi_overrun_d = spi_rd_req_i & spi_wr_req_i;
        loc_ack_d     = 1'b0;
        loc_rdata_d   = loc_rdata_q;
        slot_drain    = 1'b0;
        spi_direct    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (slot_full_q) begin
                    bank_en_d    = 1'b1;
                    bank_we_d    = slot_we_q;
                    bank_addr_d  = slot_addr_q;
                    bank_wdata_d = slot_wdata_q;
                    slot_drain   = 1'b1;
                    state_d      = StSpiAcc;
                end else if (spi_pulse) begin
                    // Empty slot: the pulse bypasses it straight into the access.
                    bank_en_d    = 1'b1;
                    bank_we_d    = spi_wr_req_i;
                    bank_addr_d  = spi_addr_i;
                    bank_wdata_d = spi_wdata_i;
                    spi_direct   = 1'b1;
                    state_d      = StSpiAcc;
                end else if (loc_req_i && !loc_ack_q) begin
                    bank_en_d    = 1'b1;
                    bank_we_d    = loc_we_i;
                    bank_addr_d  = loc_addr_i;
                    bank_wdata_d = loc_wdata_i;
                    state_d      = StLocAcc;
                end
            end
            StSpiAcc: begin
                cnt_d   = 2'd0;
                state_d = bank_we_q ? StIdle : StSpiWait;
            end
            StSpiWait: begin
                if (cnt_q == CntLast) begin
                    spi_rdata_d  = bank_rdata_i;
                    spi_rvalid_d = 1'b1;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StLocAcc: begin
                cnt_d = 2'd0;
                if (bank_we_q) begin
                    loc_ack_d = 1'b1;
                    state_d   = StLocDone;
                end else begin
                    state_d = StLocWait;
                end
            end
            StLocWait: begin
                if (cnt_q == CntLast) begin
                    loc_rdata_d = bank_rdata_i;
                    loc_ack_d   = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StLocDone: state_d = StIdle;
            default:   state_d = StIdle;
        endcase

        if (slot_drain) begin
            slot_full_d = 1'b0;
        end
        // A slot being drained this cycle can accept the next pulse.
        if (spi_pulse && !spi_direct) begin
            if (slot_full_q && !slot_drain) begin
                spi_overrun_d = 1'b1;
            end else begin
                slot_full_d  = 1'b1;
                slot_we_d    = spi_wr_req_i;
                slot_addr_d  = spi_addr_i;
                slot_wdata_d = spi_wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            slot_full_q   <= 1'b0;
            slot_we_q     <= 1'b0;
            slot_addr_q   <= '0;
            slot_wdata_q  <= '0;
            bank_en_q     <= 1'b0;
            bank_we_q     <= 1'b0;
            bank_addr_q   <= '0;
            bank_wdata_q  <= '0;
            cnt_q         <= 2'd0;
            spi_rdata_q   <= '0;
            spi_rvalid_q  <= 1'b0;
            spi_overrun_q <= 1'b0;
            loc_ack_q     <= 1'b0;
            loc_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            slot_full_q   <= slot_full_d;
            slot_we_q     <= slot_we_d;
            slot_addr_q   <= slot_addr_d;
            slot_wdata_q  <= slot_wdata_d;
            bank_en_q     <= bank_en_d;
            bank_we_q     <= bank_we_d;
            bank_addr_q   <= bank_addr_d;
            bank_wdata_q  <= bank_wdata_d;
            cnt_q         <= cnt_d;
            spi_rdata_q   <= spi_rdata_d;
            spi_rvalid_q  <= spi_rvalid_d;
            spi_overrun_q <= spi_overrun_d;
            loc_ack_q     <= loc_ack_d;
            loc_rdata_q   <= loc_rdata_d;
        end
    end

    assign spi_rdata_o   = spi_rdata_q;
    assign spi_rvalid_o  = spi_rvalid_q;
    assign spi_overrun_o = spi_overrun_q;
    assign loc_ack_o     = loc_ack_q;
    assign loc_rdata_o   = loc_rdata_q;
    assign bank_en_o     = bank_en_q;
    assign bank_we_o     = bank_we_q;
    assign bank_addr_o   = bank_addr_q;
    assign bank_wdata_o  = bank_wdata_q;
    assign busy_o        = (state_q != StIdle) || slot_full_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench: instance a uses RD_LAT=1, instance b uses RD_LAT=3; both share stimulus.
module tb_spi_reg_arbiter;

    logic        clk, rst;
    logic        spi_rd_req, spi_wr_req, loc_req, loc_we;
    logic [7:0]  spi_addr, loc_addr;
    logic [15:0] spi_wdata, loc_wdata;

    logic [15:0] a_spi_rdata, a_loc_rdata, a_bank_wdata, a_bank_rdata;
    logic        a_spi_rvalid, a_spi_overrun, a_loc_ack, a_bank_en, a_bank_we, a_busy;
    logic [7:0]  a_bank_addr;
    logic [15:0] b_spi_rdata, b_loc_rdata, b_bank_wdata, b_bank_rdata;
    logic        b_spi_rvalid, b_spi_overrun, b_loc_ack, b_bank_en, b_bank_we, b_busy;
    logic [7:0]  b_bank_addr;

    int n_total = 0;
    int n_bad   = 0;
    int a_en_cnt = 0, a_rv_cnt = 0, a_ack_cnt = 0, a_ovr_cnt = 0, b_rv_cnt = 0;
    int s_en, s_rv, s_ack, s_ovr;

    spi_reg_arbiter #(.AW(8), .DW(16), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .spi_rd_req_i(spi_rd_req), .spi_wr_req_i(spi_wr_req),
        .spi_addr_i(spi_addr), .spi_wdata_i(spi_wdata),
        .spi_rdata_o(a_spi_rdata), .spi_rvalid_o(a_spi_rvalid), .spi_overrun_o(a_spi_overrun),
        .loc_req_i(loc_req), .loc_we_i(loc_we), .loc_addr_i(loc_addr),
        .loc_wdata_i(loc_wdata), .loc_ack_o(a_loc_ack), .loc_rdata_o(a_loc_rdata),
        .bank_en_o(a_bank_en), .bank_we_o(a_bank_we), .bank_addr_o(a_bank_addr),
        .bank_wdata_o(a_bank_wdata), .bank_rdata_i(a_bank_rdata), .busy_o(a_busy)
    );

    spi_reg_arbiter #(.AW(8), .DW(16), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .spi_rd_req_i(spi_rd_req), .spi_wr_req_i(spi_wr_req),
        .spi_addr_i(spi_addr), .spi_wdata_i(spi_wdata),
        .spi_rdata_o(b_spi_rdata), .spi_rvalid_o(b_spi_rvalid), .spi_overrun_o(b_spi_overrun),
        .loc_req_i(loc_req), .loc_we_i(loc_we), .loc_addr_i(loc_addr),
        .loc_wdata_i(loc_wdata), .loc_ack_o(b_loc_ack), .loc_rdata_o(b_loc_rdata),
        .bank_en_o(b_bank_en), .bank_we_o(b_bank_we), .bank_addr_o(b_bank_addr),
        .bank_wdata_o(b_bank_wdata), .bank_rdata_i(b_bank_rdata), .busy_o(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rd_val(input logic [7:0] addr);
        return (addr == 8'h12) ? 16'hBEEF : {8'hA5, addr};
    endfunction

    // Bank models: data valid exactly RD_LAT cycles after the bank_en cycle, zero otherwise.
    logic [15:0] a_p0, b_p0, b_p1, b_p2;
    always @(posedge clk) begin
        a_p0 <= (a_bank_en && !a_bank_we) ? rd_val(a_bank_addr) : 16'h0;
        b_p0 <= (b_bank_en && !b_bank_we) ? rd_val(b_bank_addr) : 16'h0;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign a_bank_rdata = a_p0;
    assign b_bank_rdata = b_p2;

    always @(posedge clk) begin
        if (a_bank_en)     a_en_cnt  <= a_en_cnt + 1;
        if (a_spi_rvalid)  a_rv_cnt  <= a_rv_cnt + 1;
        if (a_loc_ack)     a_ack_cnt <= a_ack_cnt + 1;
        if (a_spi_overrun) a_ovr_cnt <= a_ovr_cnt + 1;
        if (b_spi_rvalid)  b_rv_cnt  <= b_rv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; spi_rd_req = 0; spi_wr_req = 0; spi_addr = 0; spi_wdata = 0;
        loc_req = 0; loc_we = 0; loc_addr = 0; loc_wdata = 0;
        tick(3);
        check("rst_bank_en", 32'(a_bank_en), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_rvalid", 32'(a_spi_rvalid), 0);
        check("rst_ack", 32'(a_loc_ack), 0);
        check("rst_addr", 32'(a_bank_addr), 0);
        rst = 1'b0;
        tick(2);

        // SPI read 0x12
        spi_rd_req = 1; spi_addr = 8'h12;
        tick(); spi_rd_req = 0;
        check("rd_en", 32'(a_bank_en), 1);
        check("rd_we", 32'(a_bank_we), 0);
        check("rd_addr", 32'(a_bank_addr), 32'h12);
        check("rd_busy", 32'(a_busy), 1);
        tick();
        check("rd_c2_rvalid", 32'(a_spi_rvalid), 0);
        check("rd_c2_en", 32'(a_bank_en), 0);
        tick();
        check("rd_rvalid", 32'(a_spi_rvalid), 1);
        check("rd_data", 32'(a_spi_rdata), 32'hBEEF);
        tick();
        check("rd_c4_rvalid", 32'(a_spi_rvalid), 0);
        check("rd_c4_busy", 32'(a_busy), 0);
        check("b_c4_rvalid", 32'(b_spi_rvalid), 0);
        tick();
        check("b_rvalid", 32'(b_spi_rvalid), 1);
        check("b_data", 32'(b_spi_rdata), 32'hBEEF);
        tick(2);

        // SPI write 0x34 <- 0x1234
        s_rv = a_rv_cnt;
        spi_wr_req = 1; spi_addr = 8'h34; spi_wdata = 16'h1234;
        tick(); spi_wr_req = 0;
        check("wr_en", 32'(a_bank_en), 1);
        check("wr_we", 32'(a_bank_we), 1);
        check("wr_addr", 32'(a_bank_addr), 32'h34);
        check("wr_wdata", 32'(a_bank_wdata), 32'h1234);
        tick();
        check("wr_c2_en", 32'(a_bank_en), 0);
        check("wr_hold_addr", 32'(a_bank_addr), 32'h34);
        check("wr_hold_wdata", 32'(a_bank_wdata), 32'h1234);
        tick(3);
        check("wr_no_rvalid", 32'(a_rv_cnt - s_rv), 0);

        // Local read 0x05 with SPI write 0x07 arriving mid-access
        s_ack = a_ack_cnt;
        loc_req = 1; loc_we = 0; loc_addr = 8'h05;
        tick();
        check("lr_en", 32'(a_bank_en), 1);
        check("lr_addr", 32'(a_bank_addr), 32'h05);
        spi_wr_req = 1; spi_addr = 8'h07; spi_wdata = 16'h0707;
        tick(); spi_wr_req = 0;
        check("lr_c2_busy", 32'(a_busy), 1);
        check("lr_c2_en", 32'(a_bank_en), 0);
        tick();
        check("lr_ack", 32'(a_loc_ack), 1);
        check("lr_rdata", 32'(a_loc_rdata), 32'hA505);
        check("lr_c3_busy", 32'(a_busy), 1);
        tick(); loc_req = 0;
        check("lr_spi_en", 32'(a_bank_en), 1);
        check("lr_spi_we", 32'(a_bank_we), 1);
        check("lr_spi_addr", 32'(a_bank_addr), 32'h07);
        check("lr_spi_wdata", 32'(a_bank_wdata), 32'h0707);
        check("lr_c4_busy", 32'(a_busy), 1);
        tick();
        check("lr_c5_en", 32'(a_bank_en), 0);
        check("lr_c5_busy", 32'(a_busy), 0);
        tick(2);
        check("lr_ack_once", 32'(a_ack_cnt - s_ack), 1);

        // SPI read and local write requested in the same idle cycle
        s_ack = a_ack_cnt;
        spi_rd_req = 1; spi_addr = 8'h21;
        loc_req = 1; loc_we = 1; loc_addr = 8'h40; loc_wdata = 16'h4444;
        tick(); spi_rd_req = 0;
        check("pr_spi_addr", 32'(a_bank_addr), 32'h21);
        check("pr_spi_we", 32'(a_bank_we), 0);
        tick(2);
        check("pr_rvalid", 32'(a_spi_rvalid), 1);
        check("pr_rdata", 32'(a_spi_rdata), 32'hA521);
        check("pr_c3_en", 32'(a_bank_en), 0);
        tick();
        check("pr_loc_en", 32'(a_bank_en), 1);
        check("pr_loc_addr", 32'(a_bank_addr), 32'h40);
        check("pr_loc_wdata", 32'(a_bank_wdata), 32'h4444);
        tick();
        check("pr_ack", 32'(a_loc_ack), 1);
        loc_req = 0;
        tick(3);
        check("pr_ack_once", 32'(a_ack_cnt - s_ack), 1);

        // Three back-to-back SPI writes during a local read
        s_en = a_en_cnt; s_ovr = a_ovr_cnt;
        loc_req = 1; loc_we = 0; loc_addr = 8'h06;
        tick();
        spi_wr_req = 1; spi_addr = 8'h50; spi_wdata = 16'h0001;
        tick();
        spi_addr = 8'h51; spi_wdata = 16'h0002;
        tick();
        check("bb_ack", 32'(a_loc_ack), 1);
        check("bb_rdata", 32'(a_loc_rdata), 32'hA506);
        check("bb_overrun", 32'(a_spi_overrun), 1);
        spi_addr = 8'h52; spi_wdata = 16'h0003;
        tick(); spi_wr_req = 0; loc_req = 0;
        check("bb_first_addr", 32'(a_bank_addr), 32'h50);
        check("bb_first_en", 32'(a_bank_en), 1);
        tick(2);
        check("bb_second_addr", 32'(a_bank_addr), 32'h52);
        check("bb_second_wdata", 32'(a_bank_wdata), 32'h0003);
        tick(3);
        check("bb_en_count", 32'(a_en_cnt - s_en), 3);
        check("bb_ovr_count", 32'(a_ovr_cnt - s_ovr), 1);

        // Reset while instance b is waiting on its read
        spi_rd_req = 1; spi_addr = 8'h33;
        tick(); spi_rd_req = 0;
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_en", 32'(b_bank_en), 0);
        check("rs_rvalid", 32'(b_spi_rvalid), 0);
        check("rs_busy", 32'(b_busy), 0);
        check("rs_rdata", 32'(b_spi_rdata), 0);
        check("rs_addr", 32'(b_bank_addr), 0);
        s_rv = b_rv_cnt;
        tick(5);
        check("rs_no_rvalid", 32'(b_rv_cnt - s_rv), 0);
        spi_rd_req = 1; spi_addr = 8'h12;
        tick(); spi_rd_req = 0;
        check("rs_new_en", 32'(b_bank_en), 1);
        tick(3);
        check("rs_new_early", 32'(b_spi_rvalid), 0);
        tick();
        check("rs_new_rvalid", 32'(b_spi_rvalid), 1);
        check("rs_new_rdata", 32'(b_spi_rdata), 32'hBEEF);
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
